// File: rtl/gift_full_enc.sv
// Iterative GIFT-128 encryption core: one round per clock, 40 rounds per block.
// Shares the load-key / load-data / busy / done handshake of the decryption core.

module gift_sbox (
  input  logic [3:0] x,
  output logic [3:0] y
);
  always_comb begin
    case (x)
      4'h0: y = 4'h1;  4'h1: y = 4'hA;  4'h2: y = 4'h4;  4'h3: y = 4'hC;
      4'h4: y = 4'h6;  4'h5: y = 4'hF;  4'h6: y = 4'h3;  4'h7: y = 4'h9;
      4'h8: y = 4'h2;  4'h9: y = 4'hD;  4'hA: y = 4'hB;  4'hB: y = 4'h7;
      4'hC: y = 4'h5;  4'hD: y = 4'h0;  4'hE: y = 4'h8;  default: y = 4'hE;
    endcase
  end
endmodule

module gift_full_enc #(
  parameter int ROUNDS = 40
) (
  input  logic         inClk,
  input  logic         inRstN,
  input  logic         inKeyWr,
  input  logic [127:0] inKeyData,
  input  logic         inDataWr,
  input  logic [127:0] inDataData,
  output logic [127:0] outData,
  output logic         outBusy,
  output logic         outDone
);
  localparam int NUM_LANES = 32;
  localparam int VEC_W     = 4;

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state, stateNxt;
  logic [127:0] masterKey, keyWork, keyNxt;
  logic [127:0] stateReg, permBits, rndOut;
  logic [5:0]   lfsr, lfsrNxt, rnd;
  logic         start, last;

  logic [NUM_LANES-1:0][VEC_W-1:0] sbIn, sbOut;

  assign start = (state == IDLE) && inDataWr;
  assign last  = (state == RUN) && (rnd == 6'(ROUNDS - 1));

  // ---------------- control FSM
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) state <= IDLE;
    else         state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (inDataWr) stateNxt = RUN;
      RUN:     if (last)     stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_comb begin
    outBusy = (state == RUN);
  end

  // ---------------- round function
  assign sbIn = stateReg;

  for (genvar g = 0; g < NUM_LANES; g++) begin : gLane
    gift_sbox uSbox (.x(sbIn[g]), .y(sbOut[g]));
  end

  // Bit i of the substituted state lands at position P(i)
  for (genvar i = 0; i < 128; i++) begin : gPerm
    assign permBits[4*(i/16) + 32*((3*((i%16)/4) + (i%4)) % 4) + (i%4)] = sbOut[i/4][i%4];
  end

  // Each round consumes the already-advanced constant
  assign lfsrNxt = {lfsr[4:0], lfsr[5] ^ lfsr[4] ^ 1'b1};

  always_comb begin
    rndOut = permBits;
    for (int i = 0; i < NUM_LANES; i++) begin
      rndOut[4*i+2] = rndOut[4*i+2] ^ keyWork[64+i];
      rndOut[4*i+1] = rndOut[4*i+1] ^ keyWork[i];
    end
    rndOut[23]  = rndOut[23] ^ lfsrNxt[5];
    rndOut[19]  = rndOut[19] ^ lfsrNxt[4];
    rndOut[15]  = rndOut[15] ^ lfsrNxt[3];
    rndOut[11]  = rndOut[11] ^ lfsrNxt[2];
    rndOut[7]   = rndOut[7]  ^ lfsrNxt[1];
    rndOut[3]   = rndOut[3]  ^ lfsrNxt[0];
    rndOut[127] = ~rndOut[127];
  end

  // k7..k0 <- (k1 >>> 2), (k0 >>> 12), k7..k2
  assign keyNxt = {keyWork[17:16], keyWork[31:18], keyWork[11:0], keyWork[15:12], keyWork[127:32]};

  // ---------------- datapath
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      masterKey <= '0;
      keyWork   <= '0;
      stateReg  <= '0;
      lfsr      <= '0;
      rnd       <= '0;
      outData   <= '0;
      outDone   <= 1'b0;
    end else begin
      outDone <= last;
      if (state == IDLE) begin
        if (inKeyWr) masterKey <= inKeyData;
        if (start) begin
          stateReg <= inDataData;
          keyWork  <= inKeyWr ? inKeyData : masterKey;
          lfsr     <= '0;
          rnd      <= '0;
        end
      end else begin
        stateReg <= rndOut;
        keyWork  <= keyNxt;
        lfsr     <= lfsrNxt;
        if (!last) rnd <= rnd + 6'd1;
        if (last)  outData <= rndOut;
      end
    end
  end

endmodule

// File: tb/tb_gift_full_enc.sv
// Self-checking bench for gift_full_enc: golden vector, handshake timing, and a
// bit-level GIFT-128 encrypt/decrypt reference model with random vectors.

module tb_gift_full_enc;
  logic         inClk = 1'b0, inRstN = 1'b0, inKeyWr = 1'b0, inDataWr = 1'b0;
  logic [127:0] inKeyData = '0, inDataData = '0;
  logic [127:0] outData;
  logic         outBusy, outDone;

  int nTests = 0, nFail = 0;
  localparam logic [127:0] ZERO_CT = 128'hcd0bd738388ad3f668b15a36ceb6ff92;

  gift_full_enc #(.ROUNDS(40)) dut (
    .inClk(inClk), .inRstN(inRstN), .inKeyWr(inKeyWr), .inKeyData(inKeyData),
    .inDataWr(inDataWr), .inDataData(inDataData),
    .outData(outData), .outBusy(outBusy), .outDone(outDone)
  );

  always #5 inClk = ~inClk;

  // ---------------- reference model
  function automatic int pIdx(input int i);
    return 4*(i/16) + 32*((3*((i%16)/4) + (i%4)) % 4) + (i%4);
  endfunction

  function automatic logic [3:0] sbx(input logic [3:0] x);
    logic [63:0] t;
    t = 64'h1A4C6F392DB7508E;
    return t[(63 - 4*int'(x)) -: 4];
  endfunction

  function automatic logic [3:0] sbxInv(input logic [3:0] y);
    for (int v = 0; v < 16; v++) if (sbx(4'(v)) == y) return 4'(v);
    return 4'h0;
  endfunction

  function automatic logic [15:0] rotr16(input logic [15:0] x, input int n);
    return (x >> n) | (x << (16 - n));
  endfunction

  function automatic logic [127:0] nextKey(input logic [127:0] key);
    logic [15:0] k[8], n[8];
    for (int j = 0; j < 8; j++) k[j] = key[16*j +: 16];
    n[7] = rotr16(k[1], 2);
    n[6] = rotr16(k[0], 12);
    for (int j = 0; j < 6; j++) n[j] = k[j+2];
    for (int j = 0; j < 8; j++) nextKey[16*j +: 16] = n[j];
  endfunction

  function automatic logic [127:0] addRk(input logic [127:0] s, input logic [127:0] key, input logic [5:0] c);
    logic [31:0] u, v;
    int cpos[6];
    cpos = '{3, 7, 11, 15, 19, 23};
    u = key[95:64];
    v = key[31:0];
    for (int i = 0; i < 32; i++) begin
      s[4*i+2] ^= u[i];
      s[4*i+1] ^= v[i];
    end
    for (int j = 0; j < 6; j++) s[cpos[j]] ^= c[j];
    s[127] ^= 1'b1;
    return s;
  endfunction

  function automatic logic [127:0] encModel(input logic [127:0] key, input logic [127:0] pt);
    logic [127:0] s, t;
    logic [5:0] c;
    s = pt; c = 6'd0;
    for (int r = 0; r < 40; r++) begin
      for (int n = 0; n < 32; n++) s[4*n +: 4] = sbx(s[4*n +: 4]);
      for (int i = 0; i < 128; i++) t[pIdx(i)] = s[i];
      c = {c[4:0], c[5] ^ c[4] ^ 1'b1};
      s = addRk(t, key, c);
      key = nextKey(key);
    end
    return s;
  endfunction

  function automatic logic [127:0] decModel(input logic [127:0] key, input logic [127:0] ct);
    logic [127:0] rk[40];
    logic [5:0]   rc[40];
    logic [127:0] s, t;
    logic [5:0]   c;
    c = 6'd0;
    for (int r = 0; r < 40; r++) begin
      c = {c[4:0], c[5] ^ c[4] ^ 1'b1};
      rc[r] = c; rk[r] = key;
      key = nextKey(key);
    end
    s = ct;
    for (int r = 39; r >= 0; r--) begin
      s = addRk(s, rk[r], rc[r]);
      for (int i = 0; i < 128; i++) t[i] = s[pIdx(i)];
      for (int n = 0; n < 32; n++) t[4*n +: 4] = sbxInv(t[4*n +: 4]);
      s = t;
    end
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- stimulus helpers (caller sits #1 after a rising edge)
  task automatic loadKey(input logic [127:0] key);
    inKeyData = key; inKeyWr = 1'b1;
    @(posedge inClk); #1;
    inKeyWr = 1'b0;
  endtask

  task automatic startBlock(input logic [127:0] pt, input bit withKey, input logic [127:0] key);
    inDataData = pt; inDataWr = 1'b1;
    inKeyData = key; inKeyWr = withKey;
    @(posedge inClk); #1;
    inDataWr = 1'b0; inKeyWr = 1'b0;
  endtask

  // Returns cycles from E0 to the first outDone (-1 on timeout) and busy cycle count
  task automatic waitDone(output int lat, output int busyCnt);
    lat = -1;
    busyCnt = outBusy ? 1 : 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge inClk); #1;
      if (outDone) begin lat = c; break; end
      if (outBusy) busyCnt++;
    end
  endtask

  // ---------------- tests
  task automatic test_reset();
    #1;
    nTests++; if (outData !== '0) begin nFail++; $display("FAIL reset_data got=%h exp=0", outData); end
    nTests++; if (outBusy !== 1'b0) begin nFail++; $display("FAIL reset_busy got=%b exp=0", outBusy); end
    nTests++; if (outDone !== 1'b0) begin nFail++; $display("FAIL reset_done got=%b exp=0", outDone); end
    @(posedge inClk); #1; inRstN = 1'b1;
    @(posedge inClk); #1;
    nTests++; if (outBusy !== 1'b0) begin nFail++; $display("FAIL reset_idle_busy got=%b exp=0", outBusy); end
  endtask

  task automatic test_zero_vector();
    int lat, bc;
    startBlock('0, 1'b0, '0);
    nTests++; if (outBusy !== 1'b1) begin nFail++; $display("FAIL zero_busy_rise got=%b exp=1", outBusy); end
    waitDone(lat, bc);
    nTests++; if (lat != 40) begin nFail++; $display("FAIL zero_latency got=%0d exp=40", lat); end
    nTests++; if (bc != 40) begin nFail++; $display("FAIL zero_busy_cycles got=%0d exp=40", bc); end
    nTests++; if (outData !== ZERO_CT) begin nFail++; $display("FAIL zero_ct got=%h exp=%h", outData, ZERO_CT); end
    nTests++; if (outData !== encModel('0, '0)) begin nFail++; $display("FAIL zero_ct_model got=%h exp=%h", outData, encModel('0, '0)); end
    nTests++; if (outBusy !== 1'b0) begin nFail++; $display("FAIL zero_busy_fall got=%b exp=0", outBusy); end
    @(posedge inClk); #1;
    nTests++; if (outDone !== 1'b0) begin nFail++; $display("FAIL zero_done_pulse got=%b exp=0", outDone); end
    nTests++; if (outData !== ZERO_CT) begin nFail++; $display("FAIL zero_ct_hold got=%h exp=%h", outData, ZERO_CT); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] key, pt;
    int lat, bc;
    key = rand128();
    loadKey(key);
    for (int b = 0; b < 3; b++) begin
      pt = rand128();
      startBlock(pt, 1'b0, '0);
      waitDone(lat, bc);
      nTests++; if (lat != 40) begin nFail++; $display("FAIL b2b_latency[%0d] got=%0d exp=40", b, lat); end
      nTests++; if (outData !== encModel(key, pt)) begin nFail++; $display("FAIL b2b_ct[%0d] got=%h exp=%h", b, outData, encModel(key, pt)); end
    end
    @(posedge inClk); #1;
  endtask

  task automatic test_ignored_strobes();
    logic [127:0] ka, pt, pt2;
    int lat, bc;
    ka = rand128(); pt = rand128(); pt2 = rand128();
    loadKey(ka);
    startBlock(pt, 1'b0, '0);
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      if (c == 5 || c == 20) begin
        inKeyWr = 1'b1; inDataWr = 1'b1; inKeyData = rand128(); inDataData = rand128();
      end
      @(posedge inClk); #1;
      inKeyWr = 1'b0; inDataWr = 1'b0;
      if (outDone) begin lat = c; break; end
    end
    nTests++; if (lat != 40) begin nFail++; $display("FAIL ign_latency got=%0d exp=40", lat); end
    nTests++; if (outData !== encModel(ka, pt)) begin nFail++; $display("FAIL ign_ct got=%h exp=%h", outData, encModel(ka, pt)); end
    startBlock(pt2, 1'b0, '0);
    waitDone(lat, bc);
    nTests++; if (outData !== encModel(ka, pt2)) begin nFail++; $display("FAIL ign_oldkey_ct got=%h exp=%h", outData, encModel(ka, pt2)); end
    @(posedge inClk); #1;
  endtask

  task automatic test_simul_key_data();
    logic [127:0] k2, pt, pt2;
    int lat, bc;
    k2 = rand128(); pt = rand128(); pt2 = rand128();
    startBlock(pt, 1'b1, k2);
    waitDone(lat, bc);
    nTests++; if (lat != 40) begin nFail++; $display("FAIL simul_latency got=%0d exp=40", lat); end
    nTests++; if (outData !== encModel(k2, pt)) begin nFail++; $display("FAIL simul_ct got=%h exp=%h", outData, encModel(k2, pt)); end
    startBlock(pt2, 1'b0, '0);
    waitDone(lat, bc);
    nTests++; if (outData !== encModel(k2, pt2)) begin nFail++; $display("FAIL simul_keykept got=%h exp=%h", outData, encModel(k2, pt2)); end
    @(posedge inClk); #1;
  endtask

  task automatic test_reset_abort();
    int lat, bc, doneSeen, busySeen;
    loadKey(rand128());
    startBlock(rand128(), 1'b0, '0);
    for (int c = 1; c <= 17; c++) begin @(posedge inClk); #1; end
    inRstN = 1'b0;
    #2;
    nTests++; if (outData !== '0) begin nFail++; $display("FAIL abort_data got=%h exp=0", outData); end
    nTests++; if (outBusy !== 1'b0) begin nFail++; $display("FAIL abort_busy got=%b exp=0", outBusy); end
    @(posedge inClk); #1; inRstN = 1'b1;
    doneSeen = 0; busySeen = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge inClk); #1;
      if (outDone) doneSeen++;
      if (outBusy) busySeen++;
    end
    nTests++; if (doneSeen != 0) begin nFail++; $display("FAIL abort_no_done got=%0d exp=0", doneSeen); end
    nTests++; if (busySeen != 0) begin nFail++; $display("FAIL abort_idle got=%0d exp=0", busySeen); end
    startBlock('0, 1'b0, '0);
    waitDone(lat, bc);
    nTests++; if (lat != 40) begin nFail++; $display("FAIL abort_rerun_latency got=%0d exp=40", lat); end
    nTests++; if (outData !== ZERO_CT) begin nFail++; $display("FAIL abort_rerun_ct got=%h exp=%h", outData, ZERO_CT); end
    @(posedge inClk); #1;
  endtask

  task automatic test_roundtrip();
    logic [127:0] key, pt, ct;
    int lat, bc;
    for (int v = 0; v < 1000; v++) begin
      key = rand128(); pt = rand128();
      startBlock(pt, 1'b1, key);
      waitDone(lat, bc);
      ct = outData;
      nTests++;
      if (lat != 40) begin nFail++; $display("FAIL rt_latency[%0d] got=%0d exp=40", v, lat); end
      else if (ct !== encModel(key, pt)) begin nFail++; $display("FAIL rt_ct[%0d] got=%h exp=%h", v, ct, encModel(key, pt)); end
      nTests++;
      if (decModel(key, ct) !== pt) begin nFail++; $display("FAIL rt_dec[%0d] got=%h exp=%h", v, decModel(key, ct), pt); end
    end
  endtask

  initial begin
    test_reset();
    test_zero_vector();
    test_back_to_back();
    test_ignored_strobes();
    test_simul_key_data();
    test_reset_abort();
    test_roundtrip();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/gift_full_enc.md
# gift_full_enc

Iterative GIFT-128 encryption core that computes one round per clock. It is the encryption counterpart of the team's iterative GIFT-128 decryption core, and it presents the same load-key / load-data / busy / result interface so that system glue can drive either core the same way. The block contains:
- a control FSM,
- a 6-bit round-constant LFSR,
- a master-key register and a working key-schedule register,
- a 128-bit round-state register,
- a registered output.

## Interface
- ROUNDS, 40: number of GIFT-128 rounds. Only 40 is supported in the product; other values are for debug.
- inClk  in  1  the single clock.
- inRstN  in  1  reset. One clock; reset is asynchronous and active-low.
- inKeyWr  in  1  strobe that loads inKeyData into the master-key register.
- inKeyData  in  128  key; bit 127 is the MSB of k7.
- inDataWr  in  1  strobe that loads the plaintext and starts encryption.
- inDataData  in  128  plaintext; bit 127 is the state MSB.
- outData  out  128  ciphertext register. It holds its value until the next result.
- outBusy  out  1  high while an encryption is in progress.
- outDone  out  1  one-cycle pulse, high in the cycle outData first shows a new result.

## Operation
- FSM states:
  - IDLE goes to RUN on inDataWr.
  - RUN goes to IDLE when the round counter reaches ROUNDS−1 at a clock edge.
- Round function, applied in order:
  - SubCells: GIFT S-box 1A4C6F392DB7508E on 32 nibbles.
  - PermBits: the GIFT-128 bit permutation.
  - AddRoundKey: U = k5‖k4 XOR into bits 4i+2, and V = k1‖k0 XOR into bits 4i+1, for i = 0..31.
  - Constant: c5..c0 XOR into bits 23, 19, 15, 11, 7, 3; a 1 XOR into bit 127.
- Round-constant LFSR:
  - Update rule: (c5..c0) ← (c4, c3, c2, c1, c0, c5⊕c4⊕1).
  - Cleared to 0 on start. Each round uses the updated value, so round 1 uses 0x01, round 2 uses 0x03, round 3 uses 0x07.
- Key update after each round: k7‖…‖k0 ← (k1⋙2)‖(k0⋙12)‖k7‖k6‖k5‖k4‖k3‖k2.
- The working key is copied from the master key on start. The master key is never modified by encryption, so back-to-back blocks under the same key need no reload.
- In IDLE:
  - inKeyWr loads the master key.
  - inDataWr loads the state register, copies the key, clears the LFSR and the round counter, and enters RUN.
- In RUN, inKeyWr and inDataWr are ignored. They are not queued.
- inKeyWr and inDataWr in the same IDLE cycle: the key load takes effect first, and the data is encrypted under inKeyData of that cycle.
- inDataWr with no prior key load: encryption runs under the reset key, which is all zero.
- Round counter: 6 bits, counting 0..ROUNDS−1. It must not wrap within a block.

## Timing
- Edge E0 is the edge at which inDataWr is sampled in IDLE. At E0 the state is loaded and outBusy rises, visible after E0.
- Edges E1..E40: one round per edge.
- At E40:
  - outData ← round-40 output.
  - outBusy → 0.
  - outDone → 1 for exactly one cycle.
- Latency: ciphertext visible 40 cycles after E0. The next inDataWr is accepted in the cycle after E40, so throughput is one block per 41 cycles.
- outBusy is high during exactly 40 cycles per block.
- Reset values: outData = 0, outBusy = 0, outDone = 0, FSM = IDLE. Master key, working key, state, LFSR and counter are all 0.
- Asserting inRstN low during RUN aborts immediately:
  - outData returns to 0 and outDone does not pulse.
  - After reset release, the core is in IDLE with key 0.
- outData changes only at E40 of a completed block.

## Test plan
- Zero key, zero plaintext → outData = cd0bd738388ad3f668b15a36ceb6ff92 exactly 40 cycles after E0; outDone is a single pulse; outBusy is high for 40 cycles.
- Key load, then 3 back-to-back blocks with inDataWr in the cycle after each outDone → each result matches the golden model, and the key is reloaded nowhere.
- inDataWr and inKeyWr pulsed with new values at cycles E5 and E20 → both ignored; the result equals the original block's ciphertext; the next block uses the old key.
- Simultaneous inKeyWr and inDataWr in IDLE with key K2 → ciphertext equals the model's output under K2, not the previous key.
- inRstN pulsed low at E17 → outData = 0, outBusy = 0, no outDone. A zero-key, zero-plaintext block run afterwards gives cd0bd738388ad3f668b15a36ceb6ff92.
- Decrypt cross-check: random key/plaintext pairs through gift_full_enc, then through the team's decryption core → decryptor output equals the original plaintext for 1000 vectors.
